mux8_rr_arbiter: RTL and testbench



---
 rtl/mux8_rr_arbiter_pkg.sv | 21 ++
 rtl/mux8_rr_arbiter_mux.sv | 31 +++
 rtl/mux8_rr_arbiter_rr_pick8.sv | 29 ++
 rtl/mux8_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants and types for the round-robin mux arbiter.
// Holds widths, requester count and the IDLE/BUSY state encoding.
package mux8_rr_arbiter_pkg;

    localparam int N     = 8;
    localparam int WIDTH = 16;
    localparam int SELW  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic [N-1:0] onehot(input logic [SELW-1:0] i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_mux.sv
// Mux8Way16: 8-input, 16-bit word multiplexer.
// Ports: a..h data words, sel index, out selected word.
module Mux8Way16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic [2:0]  sel,
    output logic [15:0] out
);

    always_comb begin
        out = a;
        unique case (sel)
            3'd0: out = a;
            3'd1: out = b;
            3'd2: out = c;
            3'd3: out = d;
            3'd4: out = e;
            3'd5: out = f;
            3'd6: out = g;
            3'd7: out = h;
            default: out = a;
        endcase
    end

endmodule

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// rr_pick8: first set bit of mask searching start, start+1, ... mod 8.
// Ports: mask, start in; any (mask non-zero) and idx (winner) out.
module rr_pick8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [N-1:0]    mask,
    input  logic [SELW-1:0] start,
    output logic            any,
    output logic [SELW-1:0] idx
);

    logic [SELW-1:0] pos;

    // Scan from the farthest offset down to zero so the closest
    // set bit to start is the last assignment and wins.
    always_comb begin
        any = 1'b0;
        idx = start;
        pos = start;
        for (int k = N - 1; k >= 0; k--) begin
            pos = start + SELW'(k);
            if (mask[pos]) begin
                any = 1'b1;
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8-way 16-bit mux among 8 requesters.
// Ports: clock, reset_n, req, in_data in; out_valid/out_data/out_ready
// channel, out_sel (mux select), grant (one-hot), ack (transfer pulse).
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic [N-1:0]       grant,
    output logic [N-1:0]       ack
);

    state_e            state_q, state_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [SELW-1:0]   out_sel_q, out_sel_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;

    logic              handshake;
    logic [N-1:0]      pick_mask;
    logic [SELW-1:0]   pick_start;
    logic              pick_any;
    logic [SELW-1:0]   pick_idx;
    logic              load;
    logic [SELW-1:0]   mux_sel;
    logic [WIDTH-1:0]  mux_out;

    assign out_valid = (state_q == BUSY);
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign grant     = grant_q;

    // A reset cycle discards the held word, so no handshake or ack
    // may be reported while reset_n is low.
    assign handshake = out_valid & out_ready & reset_n;
    assign ack       = grant_q & {N{handshake}};

    // One picker serves both paths: from ptr when idle, and from the
    // slot after the current grantee (excluding it) when finishing.
    always_comb begin
        pick_mask  = req;
        pick_start = ptr_q;
        if (state_q == BUSY) begin
            pick_mask  = req & ~grant_q;
            pick_start = out_sel_q + 3'd1;
        end
    end

    rr_pick8 u_pick (
        .mask  (pick_mask),
        .start (pick_start),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    assign load    = pick_any & ((state_q == IDLE) | handshake);
    assign mux_sel = load ? pick_idx : out_sel_q;

    Mux8Way16 u_mux (
        .a   (in_data[0*WIDTH +: WIDTH]),
        .b   (in_data[1*WIDTH +: WIDTH]),
        .c   (in_data[2*WIDTH +: WIDTH]),
        .d   (in_data[3*WIDTH +: WIDTH]),
        .e   (in_data[4*WIDTH +: WIDTH]),
        .f   (in_data[5*WIDTH +: WIDTH]),
        .g   (in_data[6*WIDTH +: WIDTH]),
        .h   (in_data[7*WIDTH +: WIDTH]),
        .sel (mux_sel),
        .out (mux_out)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        out_sel_d  = out_sel_q;
        grant_d    = grant_q;
        out_data_d = out_data_q;
        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (load) begin
                    state_d    = BUSY;
                    out_sel_d  = pick_idx;
                    grant_d    = onehot(pick_idx);
                    out_data_d = mux_out;
                end
            end
            BUSY: begin
                if (handshake) begin
                    ptr_d = out_sel_q + 3'd1;
                    if (load) begin
                        out_sel_d  = pick_idx;
                        grant_d    = onehot(pick_idx);
                        out_data_d = mux_out;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            out_sel_q  <= '0;
            grant_q    <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            out_sel_q  <= out_sel_d;
            grant_q    <= grant_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: vector table plus corner sequences.
// Inputs change just after the rising edge; outputs are checked 1ns later.
module tb_mux8_rr_arbiter;

    logic         clock;
    logic         reset_n;
    logic [7:0]   req;
    logic [127:0] in_data;
    logic         out_ready;
    logic         out_valid;
    logic [15:0]  out_data;
    logic [2:0]   out_sel;
    logic [7:0]   grant;
    logic [7:0]   ack;

    int n_pass;
    int n_total;

    typedef struct {
        logic [7:0]  req;
        logic        rdy;
        logic        v;
        logic [2:0]  sel;
        logic [7:0]  grant;
        logic [7:0]  ack;
        logic [15:0] data;
    } vec_t;

    vec_t tbl[12];

    mux8_rr_arbiter dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .grant     (grant),
        .ack       (ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] word(input int i);
        return 16'hC0D0 + 16'(i);
    endfunction

    task automatic chk(input string name, input logic v,
                       input logic [2:0] sel, input logic [7:0] g,
                       input logic [7:0] a, input logic [15:0] d);
        n_total++;
        if (out_valid === v && out_sel === sel && grant === g &&
            ack === a && out_data === d) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got v=%b sel=%0d grant=%h ack=%h data=%h want v=%b sel=%0d grant=%h ack=%h data=%h",
                     name, out_valid, out_sel, grant, ack, out_data,
                     v, sel, g, a, d);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rn, input logic [7:0] r,
                         input logic rdy);
        reset_n   = rn;
        req       = r;
        out_ready = rdy;
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset_n   = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) in_data[16*i +: 16] = word(i);

        tick();
        tick();
        chk("reset", 1'b0, 3'd0, 8'h00, 8'h00, 16'h0000);

        // All requesting: rotation 0..7,0,1, then drain to idle.
        tbl[0] = '{8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 16'h0000};
        for (int i = 0; i < 8; i++) begin
            tbl[i+1] = '{8'hFF, 1'b1, 1'b1, 3'(i), 8'(1) << i,
                         8'(1) << i, word(i)};
        end
        tbl[9]  = '{8'hFF, 1'b1, 1'b1, 3'd0, 8'h01, 8'h01, word(0)};
        tbl[10] = '{8'h00, 1'b1, 1'b1, 3'd1, 8'h02, 8'h02, word(1)};
        tbl[11] = '{8'h00, 1'b1, 1'b0, 3'd1, 8'h00, 8'h00, word(1)};

        for (int i = 0; i < 12; i++) begin
            drive(1'b1, tbl[i].req, tbl[i].rdy);
            chk($sformatf("rr_row%0d", i), tbl[i].v, tbl[i].sel,
                tbl[i].grant, tbl[i].ack, tbl[i].data);
            tick();
        end

        // Single requester 2, immediate accept.
        in_data[32 +: 16] = 16'hBEEF;
        drive(1'b1, 8'h04, 1'b1);
        tick();
        drive(1'b1, 8'h04, 1'b1);
        chk("single_grant", 1'b1, 3'd2, 8'h04, 8'h04, 16'hBEEF);
        tick();
        drive(1'b1, 8'h00, 1'b1);
        chk("single_idle", 1'b0, 3'd2, 8'h00, 8'h00, 16'hBEEF);

        // Stall with in_data changing underneath the held word.
        in_data[48 +: 16] = 16'h5A5A;
        drive(1'b1, 8'h08, 1'b0);
        tick();
        in_data[48 +: 16] = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h08, 1'b0);
            chk($sformatf("stall%0d", i), 1'b1, 3'd3, 8'h08, 8'h00,
                16'h5A5A);
            tick();
        end
        drive(1'b1, 8'h08, 1'b1);
        chk("stall_ack", 1'b1, 3'd3, 8'h08, 8'h08, 16'h5A5A);
        tick();
        drive(1'b1, 8'h00, 1'b0);
        chk("stall_idle", 1'b0, 3'd3, 8'h00, 8'h00, 16'h5A5A);

        // Pointer wrap: 7 -> 0 -> 7.
        drive(1'b1, 8'h80, 1'b1);
        tick();
        drive(1'b1, 8'h81, 1'b1);
        chk("wrap_7", 1'b1, 3'd7, 8'h80, 8'h80, word(7));
        tick();
        drive(1'b1, 8'h80, 1'b1);
        chk("wrap_0", 1'b1, 3'd0, 8'h01, 8'h01, word(0));
        tick();
        drive(1'b1, 8'h00, 1'b1);
        chk("wrap_7b", 1'b1, 3'd7, 8'h80, 8'h80, word(7));
        tick();
        drive(1'b1, 8'h00, 1'b0);
        chk("wrap_idle", 1'b0, 3'd7, 8'h00, 8'h00, word(7));

        // Requester 5 drops req before its ack.
        drive(1'b1, 8'h20, 1'b0);
        tick();
        drive(1'b1, 8'h00, 1'b0);
        chk("drop_hold", 1'b1, 3'd5, 8'h20, 8'h00, word(5));
        tick();
        drive(1'b1, 8'h00, 1'b1);
        chk("drop_ack", 1'b1, 3'd5, 8'h20, 8'h20, word(5));
        tick();
        drive(1'b1, 8'h00, 1'b0);
        chk("drop_idle", 1'b0, 3'd5, 8'h00, 8'h00, word(5));

        // Reset while busy (ptr is 6 here); pointer must return to 0.
        drive(1'b1, 8'h08, 1'b0);
        tick();
        drive(1'b0, 8'h08, 1'b1);
        chk("rst_busy", 1'b1, 3'd3, 8'h08, 8'h00, 16'h1111);
        tick();
        drive(1'b1, 8'h81, 1'b1);
        chk("rst_clear", 1'b0, 3'd0, 8'h00, 8'h00, 16'h0000);
        tick();
        drive(1'b1, 8'h00, 1'b1);
        chk("rst_ptr0", 1'b1, 3'd0, 8'h01, 8'h01, word(0));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
